quad_bowl_responder: RTL and testbench

Responder side of the `start_func`/`func_done` evaluation handshake used by the gradient-descent controller. It latches a Q8.8 point (a, b, c, d) and evaluates the separable quadratic bowl f = Σ(x − Tx)². It returns the Q24.8 value and four Q8.8 step sizes (learning rate × gradient), ready for the controller's capped subtraction. All arithmetic runs through one shared signed multiplier, sequenced by a small FSM, so the block is area-cheap and has a fixed latency.

---
 rtl/quad_bowl_responder.sv | 189 ++++++++++++++++++
 tb/tb_quad_bowl_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/quad_bowl_responder.sv
// quad_bowl_responder
// Responder for the start_func/func_done evaluation handshake. Latches a Q8.8
// point (a, b, c, d) and evaluates the separable bowl f = sum((x - Tx)^2).
// Returns f in Q24.8 and four saturated Q8.8 step sizes (LRx * df/dx).
// One shared signed multiplier, sequenced by a small FSM, gives a fixed
// latency. From the sampling edge E0: value is updated at E0+5, the diffs at
// E0+6..E0+9, and func_done rises at E0+9.
module quad_bowl_responder #(
  parameter logic signed [15:0] TARGET_A        = 16'sh0300,
  parameter logic signed [15:0] TARGET_B        = 16'shFE00,
  parameter logic signed [15:0] TARGET_C        = 16'sh0100,
  parameter logic signed [15:0] TARGET_D        = 16'sh0000,
  parameter logic signed [31:0] LEARNING_RATE_A = 32'sh0000_0030,
  parameter logic signed [31:0] LEARNING_RATE_B = 32'sh0000_0030,
  parameter logic signed [31:0] LEARNING_RATE_C = 32'sh0000_0030,
  parameter logic signed [31:0] LEARNING_RATE_D = 32'sh0000_0030
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_func,
  input  logic signed [15:0] a_in,
  input  logic signed [15:0] b_in,
  input  logic signed [15:0] c_in,
  input  logic signed [15:0] d_in,
  output logic signed [31:0] value,
  output logic signed [15:0] a_diff_out,
  output logic signed [15:0] b_diff_out,
  output logic signed [15:0] c_diff_out,
  output logic signed [15:0] d_diff_out,
  output logic               func_done,
  output logic               overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQ,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic signed [17:0] G_MAX    = 18'sd32767;
  localparam logic signed [17:0] G_MIN    = -18'sd32768;
  localparam logic signed [48:0] DIFF_MAX = 49'sd32767;
  localparam logic signed [48:0] DIFF_MIN = -49'sd32768;

  state_t             state;
  logic [1:0]         idx;
  logic signed [31:0] acc;

  // Per-axis error e_x = x - Tx, 17-bit so that no input can overflow it.
  logic signed [16:0] err_q [4];

  logic signed [16:0] err_sel;
  logic signed [31:0] lr_sel;
  logic signed [17:0] g_full;
  logic signed [15:0] g_sat;
  logic               g_ovf;
  logic signed [16:0] mul_a;
  logic signed [31:0] mul_b;
  logic signed [48:0] prod;
  logic signed [48:0] prod_shr;
  logic signed [31:0] acc_sum;
  logic signed [15:0] diff_sat;
  logic               diff_ovf;

  // Capture the error terms for all four axes when the request is accepted.
  // NOTE: err_q has no reset; it is always written in LOAD before SQ/STEP read it.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      err_q[0] <= 17'(a_in) - 17'(TARGET_A);
      err_q[1] <= 17'(b_in) - 17'(TARGET_B);
      err_q[2] <= 17'(c_in) - 17'(TARGET_C);
      err_q[3] <= 17'(d_in) - 17'(TARGET_D);
    end
  end

  // Select the active axis error and learning rate, form the saturated gradient.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    err_sel = err_q[idx];
    lr_sel  = LEARNING_RATE_A;
    case (idx)
      2'd0:    lr_sel = LEARNING_RATE_A;
      2'd1:    lr_sel = LEARNING_RATE_B;
      2'd2:    lr_sel = LEARNING_RATE_C;
      default: lr_sel = LEARNING_RATE_D;
    endcase

    g_full = {err_sel, 1'b0};
    g_ovf  = 1'b0;
    g_sat  = g_full[15:0];
    if (g_full > G_MAX) begin
      g_sat = 16'sh7FFF;
      g_ovf = 1'b1;
    end else if (g_full < G_MIN) begin
      g_sat = 16'sh8000;
      g_ovf = 1'b1;
    end
  end

  // Shared multiplier: e_x * e_x in SQ, g * LRx in STEP, both rescaled by >>> 8.
  // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
  always_comb begin
    if (state == S_SQ) begin
      mul_a = err_sel;
      mul_b = 32'(err_sel);
    end else begin
      mul_a = 17'(g_sat);
      mul_b = lr_sel;
    end
    prod     = 49'(mul_a) * 49'(mul_b);
    prod_shr = prod >>> 8;
    acc_sum  = acc + prod_shr[31:0];

    diff_ovf = 1'b0;
    diff_sat = prod_shr[15:0];
    if (prod_shr > DIFF_MAX) begin
      diff_sat = 16'sh7FFF;
      diff_ovf = 1'b1;
    end else if (prod_shr < DIFF_MIN) begin
      diff_sat = 16'sh8000;
      diff_ovf = 1'b1;
    end
  end

  // Sequencing FSM with registered results and handshake output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      acc        <= '0;
      value      <= '0;
      a_diff_out <= '0;
      b_diff_out <= '0;
      c_diff_out <= '0;
      d_diff_out <= '0;
      func_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_func) state <= S_LOAD;
        end

        S_LOAD: begin
          acc      <= '0;
          overflow <= 1'b0;
          idx      <= 2'd0;
          state    <= S_SQ;
        end

        S_SQ: begin
          acc <= acc_sum;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            value <= acc_sum;
            state <= S_STEP;
          end
        end

        S_STEP: begin
          case (idx)
            2'd0:    a_diff_out <= diff_sat;
            2'd1:    b_diff_out <= diff_sat;
            2'd2:    c_diff_out <= diff_sat;
            default: d_diff_out <= diff_sat;
          endcase
          if (g_ovf || diff_ovf) overflow <= 1'b1;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            func_done <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (!start_func) begin
            func_done <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_bowl_responder.sv
// Directed testbench for quad_bowl_responder with hand-computed expectations.
module tb_quad_bowl_responder;

  logic        clk;
  logic        rst;
  logic        start_func;
  logic [15:0] a_in, b_in, c_in, d_in;
  logic [31:0] value;
  logic [15:0] a_diff_out, b_diff_out, c_diff_out, d_diff_out;
  logic        func_done;
  logic        overflow;

  int n_checks;
  int n_fail;

  quad_bowl_responder dut (
    .clk        (clk),
    .rst        (rst),
    .start_func (start_func),
    .a_in       (a_in),
    .b_in       (b_in),
    .c_in       (c_in),
    .d_in       (d_in),
    .value      (value),
    .a_diff_out (a_diff_out),
    .b_diff_out (b_diff_out),
    .c_diff_out (c_diff_out),
    .d_diff_out (d_diff_out),
    .func_done  (func_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [31:0] ev,
                               input logic [15:0] ea, input logic [15:0] eb,
                               input logic [15:0] ec, input logic [15:0] ed,
                               input logic eo);
    check({tag, "_value"}, value, ev);
    check({tag, "_adiff"}, {16'h0, a_diff_out}, {16'h0, ea});
    check({tag, "_bdiff"}, {16'h0, b_diff_out}, {16'h0, eb});
    check({tag, "_cdiff"}, {16'h0, c_diff_out}, {16'h0, ec});
    check({tag, "_ddiff"}, {16'h0, d_diff_out}, {16'h0, ed});
    check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, eo});
  endtask

  // Full request with start dropped during LOAD; checks latency, value at E0+5,
  // final results and a one-cycle func_done pulse.
  task automatic eval_and_check(input string tag,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d,
                                input logic [31:0] ev,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [15:0] ec, input logic [15:0] ed,
                                input logic eo);
    int lat;
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; d_in = d;
    start_func = 1'b1;
    @(posedge clk);           // E0
    lat = 0;
    @(negedge clk);
    start_func = 1'b0;        // falls during LOAD, must be ignored
    while (!func_done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) check({tag, "_value_e5"}, value, ev);
    end
    check({tag, "_latency"}, lat, 9);
    check_results(tag, ev, ea, eb, ec, ed, eo);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'h0, func_done}, 32'h0);
  endtask

  initial begin
    int lat;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start_func = 1'b0;
    a_in = 16'h0300; b_in = 16'hFE00; c_in = 16'h0100; d_in = 16'h0000;
    #1;
    check("rst_done", {31'h0, func_done}, 32'h0);
    check_results("rst", 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // At the minimum.
    eval_and_check("min", 16'h0300, 16'hFE00, 16'h0100, 16'h0000,
                   32'h0000_0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    // Positive offset on a: e=2.0, sq 4.0, step 0.75.
    eval_and_check("apos", 16'h0500, 16'hFE00, 16'h0100, 16'h0000,
                   32'h0000_0400, 16'h00C0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    // Mixed axes: e = 2.0, 2.0, -1.0, -1/256; last step floors to -1 lsb.
    eval_and_check("mixed", 16'h0500, 16'h0000, 16'h0000, 16'hFFFF,
                   32'h0000_0900, 16'h00C0, 16'h00C0, 16'hFFA0, 16'hFFFF, 1'b0);
    // Positive extreme: gradient saturates to 0x7FFF.
    eval_and_check("amax", 16'h7FFF, 16'hFE00, 16'h0100, 16'h0000,
                   32'h003D_0806, 16'h17FF, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    // Negative extreme: gradient saturates to 0x8000.
    eval_and_check("amin", 16'h8000, 16'hFE00, 16'h0100, 16'h0000,
                   32'h0043_0900, 16'hE800, 16'h0000, 16'h0000, 16'h0000, 1'b1);

    // start held high through DONE; negative offset on a; overflow cleared.
    @(negedge clk);
    a_in = 16'h0100; b_in = 16'hFE00; c_in = 16'h0100; d_in = 16'h0000;
    start_func = 1'b1;
    @(posedge clk);
    lat = 0;
    while (!func_done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_latency", lat, 9);
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_high", {31'h0, func_done}, 32'h1);
    check_results("hold", 32'h0000_0400, 16'hFF40, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    start_func = 1'b0;
    @(posedge clk);
    #1;
    check("hold_done_fall", {31'h0, func_done}, 32'h0);
    check("hold_adiff_kept", {16'h0, a_diff_out}, 32'h0000_FF40);

    // Re-raise start: second result correct.
    eval_and_check("rerun", 16'h0500, 16'hFE00, 16'h0100, 16'h0000,
                   32'h0000_0400, 16'h00C0, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // Input change after latching is ignored.
    @(negedge clk);
    a_in = 16'h0500; b_in = 16'hFE00; c_in = 16'h0100; d_in = 16'h0000;
    start_func = 1'b1;
    @(posedge clk);           // E0
    @(negedge clk);
    start_func = 1'b0;
    @(posedge clk);           // E0+1, inputs latched
    lat = 1;
    @(negedge clk);
    a_in = 16'h7FFF;
    while (!func_done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("instab_latency", lat, 9);
    check_results("instab", 32'h0000_0400, 16'h00C0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);

    // Reset asserted mid-SQ clears everything immediately.
    @(negedge clk);
    a_in = 16'h7FFF;
    start_func = 1'b1;
    @(posedge clk);           // E0
    @(posedge clk);           // LOAD
    @(posedge clk);           // first SQ axis
    #2;
    rst = 1'b1;
    #1;
    check("midrst_done", {31'h0, func_done}, 32'h0);
    check_results("midrst", 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    start_func = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("postrst_idle_done", {31'h0, func_done}, 32'h0);
    check("postrst_idle_value", value, 32'h0);

    eval_and_check("postrst", 16'h0500, 16'h0000, 16'h0000, 16'hFFFF,
                   32'h0000_0900, 16'h00C0, 16'h00C0, 16'hFFA0, 16'hFFFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
